// File: rtl/riscv_v_pkg.sv
// Shared types for the vector LMUL micro-op sequencer.
// Holds FSM states, vlmul encodings, the micro-op bundle and the group-size helper.
package riscv_v_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } riscv_v_seq_state_e;

  typedef enum logic [2:0] {
    LMUL_1   = 3'b000,
    LMUL_2   = 3'b001,
    LMUL_4   = 3'b010,
    LMUL_8   = 3'b011,
    LMUL_RSV = 3'b100,
    LMUL_F8  = 3'b101,
    LMUL_F4  = 3'b110,
    LMUL_F2  = 3'b111
  } riscv_v_vlmul_e;

  typedef struct packed {
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [2:0] idx;
    logic       first;
    logic       last;
  } riscv_v_uop_t;

  // Reserved and fractional groups still occupy one register.
  function automatic logic [3:0] lmul_count(input logic [2:0] vlmul);
    logic [3:0] cnt;
    unique case (vlmul)
      LMUL_2:  cnt = 4'd2;
      LMUL_4:  cnt = 4'd4;
      LMUL_8:  cnt = 4'd8;
      default: cnt = 4'd1;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/riscv_v_lmul_sequencer_if.sv
// Decode-to-execute handshake bundle for the LMUL sequencer.
// master = environment side, slave = sequencer side.
interface riscv_v_lmul_sequencer_if #(
  parameter int VL_W = 8
);
  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      issue_vd;
  logic [4:0]      issue_vs1;
  logic [4:0]      issue_vs2;
  logic            issue_vs1_is_vec;
  logic [2:0]      issue_vlmul;
  logic [2:0]      issue_vsew;
  logic [VL_W-1:0] issue_vl;
  logic            flush;
  logic            uop_valid;
  logic            uop_ready;
  logic [4:0]      uop_vd;
  logic [4:0]      uop_vs1;
  logic [4:0]      uop_vs2;
  logic [2:0]      uop_idx;
  logic            uop_first;
  logic            uop_last;
  logic            busy;

  modport master (
    output issue_valid, issue_vd, issue_vs1, issue_vs2,
    output issue_vs1_is_vec, issue_vlmul, issue_vsew, issue_vl,
    output flush, uop_ready,
    input  issue_ready, uop_valid, uop_vd, uop_vs1, uop_vs2,
    input  uop_idx, uop_first, uop_last, busy
  );

  modport slave (
    input  issue_valid, issue_vd, issue_vs1, issue_vs2,
    input  issue_vs1_is_vec, issue_vlmul, issue_vsew, issue_vl,
    input  flush, uop_ready,
    output issue_ready, uop_valid, uop_vd, uop_vs1, uop_vs2,
    output uop_idx, uop_first, uop_last, busy
  );
endinterface

// File: rtl/riscv_v_uop_count.sv
// Last micro-op index of a group from vlmul (and vsew/vl when
// RISCV_V_VL_SKIP_EN trims registers lying entirely beyond vl).
module riscv_v_uop_count
  import riscv_v_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VL_W = 8
) (
  input  logic [2:0]      vlmul,
  input  logic [2:0]      vsew,
  input  logic [VL_W-1:0] vl,
  output logic [2:0]      last_idx
);
  logic [3:0] cnt;

  assign cnt = lmul_count(vlmul);

`ifdef RISCV_V_VL_SKIP_EN
  localparam int LOG_VLEN = $clog2(VLEN);
  localparam int VW       = VL_W + 1;

  logic [2:0]    sew_sh;
  logic [5:0]    epr_sh;
  logic [VW-1:0] vl_bias;
  logic [VW-1:0] grp;
  logic [3:0]    lim;

  // EPR is a power of two, so ceil(vl/EPR) is a biased shift.
  always_comb begin
    sew_sh  = vsew[2] ? 3'd0 : {1'b0, vsew[1:0]};
    epr_sh  = 6'(LOG_VLEN - 3) - 6'(sew_sh);
    vl_bias = {1'b0, vl} + ((VW'(1) << epr_sh) - VW'(1));
    grp     = vl_bias >> epr_sh;
    if (grp == '0) begin
      lim = 4'd1;
    end else if (grp > VW'(cnt)) begin
      lim = cnt;
    end else begin
      lim = grp[3:0];
    end
    last_idx = 3'(lim - 4'd1);
  end
`else
  logic unused_vl;

  assign unused_vl = ^{vsew, vl, VLEN[0]};
  assign last_idx  = 3'(cnt - 4'd1);
`endif

endmodule

// File: rtl/riscv_v_lmul_sequencer.sv
// Splits each vector instruction into one micro-op per LMUL register.
// Optional vl trimming: RISCV_V_VL_SKIP_EN (see riscv_v_uop_count).
module riscv_v_lmul_sequencer
  import riscv_v_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VL_W = $clog2(VLEN) + 1
) (
  input logic clk,
  input logic rst,
  riscv_v_lmul_sequencer_if.slave bus
);
  riscv_v_seq_state_e state_q, state_d;
  riscv_v_uop_t       uop_q, uop_d;
  logic [2:0]         last_idx_q, last_idx_d;
  logic [2:0]         cnt_last;
  logic               is_vec_q, is_vec_d;
  logic               run;
  logic               fire;
  logic               done;
  logic               rdy;

  riscv_v_uop_count #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) u_cnt (
    .vlmul    (bus.issue_vlmul),
    .vsew     (bus.issue_vsew),
    .vl       (bus.issue_vl),
    .last_idx (cnt_last)
  );

  assign run  = (state_q == RUN);
  assign fire = run && bus.uop_ready;
  assign done = fire && uop_q.last;

  always_comb begin
    state_d    = state_q;
    uop_d      = uop_q;
    last_idx_d = last_idx_q;
    is_vec_d   = is_vec_q;
    rdy        = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      rdy = !run || done;
      if (rdy && bus.issue_valid) begin
        state_d     = RUN;
        is_vec_d    = bus.issue_vs1_is_vec;
        last_idx_d  = cnt_last;
        uop_d.vd    = bus.issue_vd;
        uop_d.vs1   = bus.issue_vs1;
        uop_d.vs2   = bus.issue_vs2;
        uop_d.idx   = 3'd0;
        uop_d.first = 1'b1;
        uop_d.last  = (cnt_last == 3'd0);
      end else if (done) begin
        state_d = IDLE;
      end else if (fire) begin
        // Register indices wrap modulo 32 by width.
        uop_d.vd    = uop_q.vd + 5'd1;
        uop_d.vs2   = uop_q.vs2 + 5'd1;
        uop_d.vs1   = uop_q.vs1 + {4'd0, is_vec_q};
        uop_d.idx   = uop_q.idx + 3'd1;
        uop_d.first = 1'b0;
        uop_d.last  = ((uop_q.idx + 3'd1) == last_idx_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      uop_q      <= '0;
      last_idx_q <= '0;
      is_vec_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      uop_q      <= uop_d;
      last_idx_q <= last_idx_d;
      is_vec_q   <= is_vec_d;
    end
  end

  assign bus.issue_ready = rdy;
  assign bus.uop_valid   = run;
  assign bus.busy        = run;
  assign bus.uop_vd      = uop_q.vd;
  assign bus.uop_vs1     = uop_q.vs1;
  assign bus.uop_vs2     = uop_q.vs2;
  assign bus.uop_idx     = uop_q.idx;
  assign bus.uop_first   = uop_q.first;
  assign bus.uop_last    = uop_q.last;

endmodule

// File: tb/tb_riscv_v_lmul_sequencer.sv
// Self-checking bench for riscv_v_lmul_sequencer: directed scenarios
// plus randomized traffic against a queue-based micro-op model.
module tb_riscv_v_lmul_sequencer;
  localparam int VLEN = 128;
  localparam int VL_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  riscv_v_lmul_sequencer_if #(.VL_W(VL_W)) bus ();

  riscv_v_lmul_sequencer #(
    .VLEN (VLEN),
    .VL_W (VL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int vd;
    int vs1;
    int vs2;
    int idx;
    bit first;
    bit last;
  } exp_t;

  exp_t exp_q[$];

  function automatic int exp_count(int vlmul, int vsew, int vl);
    int cnt;
`ifdef RISCV_V_VL_SKIP_EN
    int sew;
    int epr;
    int g;
`endif
    cnt = (vlmul < 4) ? (1 << vlmul) : 1;
`ifdef RISCV_V_VL_SKIP_EN
    sew = (vsew < 4) ? (8 << vsew) : 8;
    epr = VLEN / sew;
    g   = (vl + epr - 1) / epr;
    if (g < 1) g = 1;
    if (g < cnt) cnt = g;
`endif
    return cnt;
  endfunction

  task automatic push_instr(int vd, int vs1, int vs2, bit vec,
                            int vlmul, int vsew, int vl);
    int n;
    n = exp_count(vlmul, vsew, vl);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.vd    = (vd + i) % 32;
      e.vs1   = vec ? (vs1 + i) % 32 : vs1;
      e.vs2   = (vs2 + i) % 32;
      e.idx   = i;
      e.first = (i == 0);
      e.last  = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_issue(bit v, int vd, int vs1, int vs2, bit vec,
                           int vlmul, int vsew, int vl);
    bus.issue_valid      = v;
    bus.issue_vd         = 5'(vd);
    bus.issue_vs1        = 5'(vs1);
    bus.issue_vs2        = 5'(vs2);
    bus.issue_vs1_is_vec = vec;
    bus.issue_vlmul      = 3'(vlmul);
    bus.issue_vsew       = 3'(vsew);
    bus.issue_vl         = VL_W'(vl);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.uop_vd !== 5'd0 || bus.uop_vs1 !== 5'd0 ||
        bus.uop_vs2 !== 5'd0 || bus.uop_idx !== 3'd0 ||
        bus.uop_first !== 1'b0 || bus.uop_last !== 1'b0 ||
        bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b vd=%0d vs1=%0d vs2=%0d idx=%0d f=%b l=%b rdy=%b (want 0s, rdy=1)",
               bus.uop_valid, bus.busy, bus.uop_vd, bus.uop_vs1, bus.uop_vs2,
               bus.uop_idx, bus.uop_first, bus.uop_last, bus.issue_ready);
    end
  endtask

  task automatic test_lmul8();
    @(negedge clk);
    set_issue(1, 8, 16, 24, 1, 3, 0, 128);
    bus.uop_ready = 1'b1;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL lmul8_accept: issue_ready=%b want 1", bus.issue_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      #1;
      checks++;
      if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'(8 + i) ||
          bus.uop_vs1 !== 5'(16 + i) || bus.uop_vs2 !== 5'(24 + i) ||
          bus.uop_idx !== 3'(i) || bus.uop_first !== (i == 0) ||
          bus.uop_last !== (i == 7) || bus.issue_ready !== (i == 7)) begin
        errors++;
        $display("FAIL lmul8 i=%0d: valid=%b vd=%0d vs1=%0d vs2=%0d idx=%0d f=%b l=%b rdy=%b want vd=%0d vs1=%0d vs2=%0d",
                 i, bus.uop_valid, bus.uop_vd, bus.uop_vs1, bus.uop_vs2,
                 bus.uop_idx, bus.uop_first, bus.uop_last, bus.issue_ready,
                 8 + i, 16 + i, 24 + i);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL lmul8_end: valid=%b busy=%b want 0 0", bus.uop_valid, bus.busy);
    end
  endtask

  task automatic test_wrap();
    int vd_exp[4];
    vd_exp[0] = 30;
    vd_exp[1] = 31;
    vd_exp[2] = 0;
    vd_exp[3] = 1;
    @(negedge clk);
    set_issue(1, 30, 5, 3, 0, 2, 0, 128);
    bus.uop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      #1;
      checks++;
      if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'(vd_exp[i]) ||
          bus.uop_vs1 !== 5'd5 || bus.uop_vs2 !== 5'(3 + i) ||
          bus.uop_last !== (i == 3)) begin
        errors++;
        $display("FAIL wrap i=%0d: valid=%b vd=%0d vs1=%0d vs2=%0d l=%b want vd=%0d vs1=5 vs2=%0d",
                 i, bus.uop_valid, bus.uop_vd, bus.uop_vs1, bus.uop_vs2,
                 bus.uop_last, vd_exp[i], 3 + i);
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    set_issue(1, 4, 10, 20, 1, 1, 0, 128);
    bus.uop_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      #1;
      checks++;
      if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'd4 ||
          bus.uop_vs1 !== 5'd10 || bus.uop_vs2 !== 5'd20 ||
          bus.uop_idx !== 3'd0 || bus.uop_first !== 1'b1 ||
          bus.uop_last !== 1'b0 || bus.issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold k=%0d: valid=%b vd=%0d vs1=%0d vs2=%0d idx=%0d f=%b l=%b rdy=%b want 1 4 10 20 0 1 0 0",
                 k, bus.uop_valid, bus.uop_vd, bus.uop_vs1, bus.uop_vs2,
                 bus.uop_idx, bus.uop_first, bus.uop_last, bus.issue_ready);
      end
    end
    @(negedge clk);
    bus.uop_ready = 1'b1;
    #1;
    checks++;
    if (bus.uop_idx !== 3'd0 || bus.uop_vd !== 5'd4) begin
      errors++;
      $display("FAIL ready_rise: idx=%0d vd=%0d want 0 4", bus.uop_idx, bus.uop_vd);
    end
    @(negedge clk);
    set_issue(1, 12, 1, 2, 0, 0, 0, 0);
    #1;
    checks++;
    if (bus.uop_valid !== 1'b1 || bus.uop_idx !== 3'd1 ||
        bus.uop_vd !== 5'd5 || bus.uop_vs1 !== 5'd11 ||
        bus.uop_last !== 1'b1 || bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL idx1: valid=%b idx=%0d vd=%0d vs1=%0d l=%b rdy=%b want 1 1 5 11 1 1",
               bus.uop_valid, bus.uop_idx, bus.uop_vd, bus.uop_vs1,
               bus.uop_last, bus.issue_ready);
    end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.uop_valid !== 1'b1 || bus.uop_vd !== 5'd12 ||
        bus.uop_vs1 !== 5'd1 || bus.uop_idx !== 3'd0 ||
        bus.uop_first !== 1'b1 || bus.uop_last !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: valid=%b vd=%0d vs1=%0d idx=%0d f=%b l=%b want 1 12 1 0 1 1",
               bus.uop_valid, bus.uop_vd, bus.uop_vs1, bus.uop_idx,
               bus.uop_first, bus.uop_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b want 0", bus.uop_valid);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_issue(1, 0, 0, 0, 1, 3, 0, 128);
    bus.uop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      if (i == 3) begin
        set_issue(1, 7, 7, 7, 1, 3, 0, 128);
        bus.flush = 1'b1;
      end
      #1;
    end
    checks++;
    if (bus.uop_idx !== 3'd3 || bus.issue_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: idx=%0d rdy=%b want 3 0", bus.uop_idx, bus.issue_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0 || bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: valid=%b busy=%b rdy=%b want 0 0 1",
               bus.uop_valid, bus.busy, bus.issue_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_nocapture: valid=%b want 0", bus.uop_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_issue(1, 9, 9, 9, 1, 3, 0, 128);
    bus.uop_ready = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.uop_vd !== 5'd0 || bus.uop_vs1 !== 5'd0 ||
        bus.uop_vs2 !== 5'd0 || bus.uop_idx !== 3'd0 ||
        bus.uop_first !== 1'b0 || bus.uop_last !== 1'b0 ||
        bus.issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b vd=%0d vs1=%0d vs2=%0d idx=%0d f=%b l=%b rdy=%b (want 0s, rdy=1)",
               bus.uop_valid, bus.busy, bus.uop_vd, bus.uop_vs1, bus.uop_vs2,
               bus.uop_idx, bus.uop_first, bus.uop_last, bus.issue_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_lost: valid=%b want 0", bus.uop_valid);
    end
  endtask

  task automatic test_count(string name, int vlmul, int vsew, int vl);
    int n;
    int expn;
    bit ok;
    n    = 0;
    ok   = 1'b1;
    expn = exp_count(vlmul, vsew, vl);
    @(negedge clk);
    set_issue(1, 1, 2, 3, 1, vlmul, vsew, vl);
    bus.uop_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus.issue_valid = 1'b0;
      #1;
      if (bus.uop_valid === 1'b1) begin
        if (bus.uop_idx !== 3'(n) || bus.uop_first !== (n == 0) ||
            bus.uop_last !== (n == expn - 1)) ok = 1'b0;
        n++;
      end
    end
    checks++;
    if (n != expn || !ok) begin
      errors++;
      $display("FAIL count_%s: uops=%0d flags_ok=%0b want uops=%0d flags_ok=1",
               name, n, ok, expn);
    end
  endtask

  task automatic test_random();
    bit   pend;
    bit   fl;
    bit   exp_rdy;
    int   p_vd, p_vs1, p_vs2, p_lmul, p_sew, p_vl;
    bit   p_vec;
    exp_t h;
    pend = 1'b0;
    exp_q.delete();
    p_vd = 0; p_vs1 = 0; p_vs2 = 0; p_lmul = 0; p_sew = 0; p_vl = 0;
    p_vec = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!pend && ($urandom % 3) != 0) begin
        pend   = 1'b1;
        p_vd   = int'($urandom % 32);
        p_vs1  = int'($urandom % 32);
        p_vs2  = int'($urandom % 32);
        p_vec  = 1'($urandom % 2);
        p_lmul = int'($urandom % 8);
        p_sew  = int'($urandom % 8);
        p_vl   = int'($urandom_range(0, VLEN));
      end
      set_issue(pend, p_vd, p_vs1, p_vs2, p_vec, p_lmul, p_sew, p_vl);
      bus.uop_ready = (($urandom % 4) != 0);
      fl = (($urandom % 25) == 0);
      bus.flush = fl;
      #1;
      checks++;
      if (bus.uop_valid !== (exp_q.size() != 0) || bus.busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid c=%0d: valid=%b busy=%b want %0b",
                 c, bus.uop_valid, bus.busy, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        checks++;
        if (bus.uop_vd !== 5'(h.vd) || bus.uop_vs1 !== 5'(h.vs1) ||
            bus.uop_vs2 !== 5'(h.vs2) || bus.uop_idx !== 3'(h.idx) ||
            bus.uop_first !== h.first || bus.uop_last !== h.last) begin
          errors++;
          $display("FAIL rnd_uop c=%0d: vd=%0d vs1=%0d vs2=%0d idx=%0d f=%b l=%b want %0d %0d %0d %0d %b %b",
                   c, bus.uop_vd, bus.uop_vs1, bus.uop_vs2, bus.uop_idx,
                   bus.uop_first, bus.uop_last,
                   h.vd, h.vs1, h.vs2, h.idx, h.first, h.last);
        end
      end
      exp_rdy = !fl && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.uop_ready));
      checks++;
      if (bus.issue_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_ready c=%0d: issue_ready=%b want %b", c, bus.issue_ready, exp_rdy);
      end
      if (fl) begin
        exp_q.delete();
      end else begin
        if (bus.uop_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (pend && exp_rdy) begin
          push_instr(p_vd, p_vs1, p_vs2, p_vec, p_lmul, p_sew, p_vl);
          pend = 1'b0;
        end
      end
    end
    @(negedge clk);
    bus.flush = 1'b0;
    bus.issue_valid = 1'b0;
    bus.uop_ready = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.flush = 1'b0;
    bus.uop_ready = 1'b0;
    set_issue(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_lmul8();
    test_wrap();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_count("vl9", 3, 2, 9);
    test_count("vl0", 3, 2, 0);
    test_count("frac", 6, 0, 128);
    test_count("rsv", 4, 0, 128);
    test_count("lmul4", 2, 0, 128);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
